// File: rtl/mips_mc_pkg.sv
// Shared constants for the manycore MIPS shared-memory path: window geometry and
// arbiter state encodings.
package mips_mc_pkg;

  localparam logic [31:0] SHARED_BASE  = 32'd128;
  localparam int unsigned SHARED_WORDS = 32;
  localparam int unsigned MEM_AW       = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

endpackage

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after rr_ptr_i,
// wrapping modulo N. Reusable by other arbiters.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  int unsigned cand;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (int'(rr_ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one shared-data RAM port among NUM_CORES cores.
// Optional bus locking for atomic RMW is enabled with `define SHARED_ARB_LOCK_EN.
module shared_mem_arbiter #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned IDX_W        = 2,
  parameter logic [31:0] SHARED_BASE  = mips_mc_pkg::SHARED_BASE,
  parameter int unsigned SHARED_WORDS = mips_mc_pkg::SHARED_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SHARED_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]    lock,
`endif
  input  logic [NUM_CORES-1:0]    req,
  input  logic [NUM_CORES-1:0]    we,
  input  logic [32*NUM_CORES-1:0] addr_bus,
  input  logic [32*NUM_CORES-1:0] wdata_bus,
  output logic [NUM_CORES-1:0]    ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [4:0]              mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic [IDX_W-1:0]        grant_idx
);

  import mips_mc_pkg::*;

  localparam logic [31:0] SHARED_END = SHARED_BASE + 32'(SHARED_WORDS * 4);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             flag_q, flag_d;

  logic [IDX_W-1:0] pick_idx, load_idx;
  logic             pick_valid, load_en, in_win;
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]      addr_a  [NUM_CORES];
  logic [31:0]      wdata_a [NUM_CORES];

  rr_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      addr_a[i]  = addr_bus[32*i +: 32];
      wdata_a[i] = wdata_bus[32*i +: 32];
    end
  end

  assign in_win   = (addr_q[1:0] == 2'b00) && (addr_q >= SHARED_BASE) && (addr_q < SHARED_END);
  assign word_idx = MEM_AW'((addr_q - SHARED_BASE) >> 2);

  assign mem_en    = (state_q == ST_ACCESS) && in_win;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? word_idx : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  always_comb begin
    ack = '0;
    if (state_q == ST_ACK) ack[owner_q] = 1'b1;
  end

  // Writes present zero in their ack cycle; the last read value stays in rdata_q.
  assign rdata     = (state_q == ST_ACK && we_q) ? '0 : rdata_q;
  assign err       = (state_q == ST_ACK) && flag_q;
  assign grant_idx = owner_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    flag_d   = flag_q;
    load_en  = 1'b0;
    load_idx = pick_idx;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          load_en = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        flag_d = !in_win;
        if (!in_win)   rdata_d = '0;
        else if (!we_q) rdata_d = mem_rdata;
        state_d = ST_ACK;
      end
      ST_ACK: begin
`ifdef SHARED_ARB_LOCK_EN
        if (lock[owner_q]) begin
          state_d = ST_LOCKED;
        end else begin
          rr_ptr_d = owner_q;
          state_d  = ST_IDLE;
        end
`else
        rr_ptr_d = owner_q;
        state_d  = ST_IDLE;
`endif
      end
`ifdef SHARED_ARB_LOCK_EN
      ST_LOCKED: begin
        if (!lock[owner_q]) begin
          rr_ptr_d = owner_q;
          state_d  = ST_IDLE;
        end else if (req[owner_q]) begin
          load_en  = 1'b1;
          load_idx = owner_q;
          state_d  = ST_ACCESS;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (load_en) begin
      owner_d = load_idx;
      we_d    = we[load_idx];
      addr_d  = addr_a[load_idx];
      wdata_d = wdata_a[load_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_CORES - 1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      flag_q   <= flag_d;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: single-core vector table plus sequences for
// fairness, contention, reset mid-access and (with SHARED_ARB_LOCK_EN) locking.
module tb_shared_mem_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req, we;
  logic [127:0] addr_bus, wdata_bus;
  logic [3:0]   ack;
  logic [31:0]  rdata;
  logic         err, mem_en, mem_we;
  logic [4:0]   mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic [1:0]   grant_idx;
`ifdef SHARED_ARB_LOCK_EN
  logic [3:0]   lock;
`endif

  logic [31:0] ram [32];
  int n_cmp = 0;
  int n_bad = 0;

  shared_mem_arbiter #(.NUM_CORES(4), .IDX_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SHARED_ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .we        (we),
    .addr_bus  (addr_bus),
    .wdata_bus (wdata_bus),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared RAM: combinational read, synchronous write, preloaded while reset is high.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'd0;
      ram[0] <= 32'd50;
      ram[1] <= 32'd25;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    int          core;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic [4:0]  exp_idx;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    req[c]              = r;
    we[c]               = w;
    addr_bus[32*c +: 32]  = a;
    wdata_bus[32*c +: 32] = d;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n);
    n = 0;
    a = 4'd0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (ack != 4'd0) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    set_core(v.core, 1'b1, v.wr, v.addr, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d access mem_en", k), 32'(mem_en), 32'(v.exp_en));
    chk($sformatf("v%0d access ack", k), 32'(ack), 32'd0);
    if (v.exp_en) begin
      chk($sformatf("v%0d mem_addr", k), 32'(mem_addr), 32'(v.exp_idx));
      chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(v.wr));
      if (v.wr) chk($sformatf("v%0d mem_wdata", k), mem_wdata, v.wdata);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d ack", k), 32'(ack), 32'(1) << v.core);
    chk($sformatf("v%0d rdata", k), rdata, v.exp_rdata);
    chk($sformatf("v%0d err", k), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d grant_idx", k), 32'(grant_idx), 32'(v.core));
    set_core(v.core, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [3:0] a;
  int         n;

  initial begin
    //            core we   addr        wdata          en   idx    rdata          err
    vecs[0] = '{1, 1'b0, 32'd128, 32'd0,          1'b1, 5'd0,  32'd50,         1'b0};
    vecs[1] = '{3, 1'b0, 32'd4,   32'd0,          1'b0, 5'd0,  32'd0,          1'b1};
    vecs[2] = '{3, 1'b0, 32'd130, 32'd0,          1'b0, 5'd0,  32'd0,          1'b1};
    vecs[3] = '{2, 1'b1, 32'd252, 32'd77,         1'b1, 5'd31, 32'd0,          1'b0};
    vecs[4] = '{2, 1'b0, 32'd252, 32'd0,          1'b1, 5'd31, 32'd77,         1'b0};
    vecs[5] = '{0, 1'b0, 32'd256, 32'd0,          1'b0, 5'd0,  32'd0,          1'b1};
    vecs[6] = '{0, 1'b0, 32'd124, 32'd0,          1'b0, 5'd0,  32'd0,          1'b1};
    vecs[7] = '{1, 1'b1, 32'd136, 32'hDEADBEEF,   1'b1, 5'd2,  32'd0,          1'b0};
    vecs[8] = '{1, 1'b0, 32'd136, 32'd0,          1'b1, 5'd2,  32'hDEADBEEF,   1'b0};
    vecs[9] = '{0, 1'b1, 32'd140, 32'd5,          1'b1, 5'd3,  32'd0,          1'b0};

    reset = 1'b1;
    req = '0; we = '0; addr_bus = '0; wdata_bus = '0;
`ifdef SHARED_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset grant_idx", 32'(grant_idx), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);
    chk("rdata holds after write", rdata, 32'hDEADBEEF);

    // All four cores store their index to 144 at once: strict 0,1,2,3 order.
    do_reset();
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 32'd144, 32'(i));
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, n);
      chk($sformatf("rr ack %0d", i), 32'(a), 32'(1) << i);
      chk($sformatf("rr spacing %0d", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
      chk($sformatf("rr err %0d", i), 32'(err), 32'd0);
      set_core(i, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    @(posedge clk); #1;
    chk("ram[4] after rr", ram[4], 32'd3);

    // Core 2 load contends with core 0 store to an illegal address.
    set_core(2, 1'b1, 1'b0, 32'd132, 32'd0);
    set_core(0, 1'b1, 1'b1, 32'd0, 32'd0);
    wait_ack(a, n);
    chk("contend first ack", 32'(a), 32'b0001);
    chk("contend first err", 32'(err), 32'd1);
    set_core(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(a, n);
    chk("contend second ack", 32'(a), 32'b0100);
    chk("contend second spacing", 32'(n), 32'd3);
    chk("contend second rdata", rdata, 32'd25);
    chk("contend second err", 32'(err), 32'd0);
    set_core(2, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Reset lands in the ACCESS cycle of a core 2 load.
    set_core(2, 1'b1, 1'b0, 32'd128, 32'd0);
    @(posedge clk); #1;
    chk("pre-reset mem_en", 32'(mem_en), 32'd1);
    reset = 1'b1;
    req = '0;
    #1;
    chk("reset-mid mem_en", 32'(mem_en), 32'd0);
    chk("reset-mid ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("reset-hold ack", 32'(ack), 32'd0);
    reset = 1'b0;
    set_core(0, 1'b1, 1'b0, 32'd128, 32'd0);
    set_core(3, 1'b1, 1'b0, 32'd128, 32'd0);
    wait_ack(a, n);
    chk("post-reset winner", 32'(a), 32'b0001);
    chk("post-reset latency", 32'(n), 32'd2);
    chk("post-reset rdata", rdata, 32'd50);
    set_core(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(a, n);
    chk("post-reset second", 32'(a), 32'b1000);
    set_core(3, 1'b0, 1'b0, 32'd0, 32'd0);

`ifdef SHARED_ARB_LOCK_EN
    // Core 1 holds the bus for a read-modify-write while core 0 waits.
    do_reset();
    lock[1] = 1'b1;
    set_core(1, 1'b1, 1'b0, 32'd128, 32'd0);
    wait_ack(a, n);
    chk("lock rd ack", 32'(a), 32'b0010);
    chk("lock rd rdata", rdata, 32'd50);
    set_core(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_core(0, 1'b1, 1'b0, 32'd128, 32'd0);
    @(posedge clk); #1;
    set_core(1, 1'b1, 1'b1, 32'd128, 32'd51);
    wait_ack(a, n);
    chk("lock wr ack", 32'(a), 32'b0010);
    set_core(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lock starve %0d", i), 32'(ack), 32'd0);
    end
    lock[1] = 1'b0;
    wait_ack(a, n);
    chk("unlock ack", 32'(a), 32'b0001);
    chk("unlock latency", 32'(n), 32'd3);
    chk("unlock rdata", rdata, 32'd51);
    set_core(0, 1'b0, 1'b0, 32'd0, 32'd0);
`endif

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter that shares the single shared-data-memory port between NUM_CORES single-cycle MIPS cores in the manycore build.
- Each core's load/store to the shared window (byte address 128 upward) arrives as a request. The arbiter serialises these onto one memory port and returns read data with a one-cycle ack.
- Sits between the per-core memory-stage address decode and the shared RAM instance.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- IDX_W, 2, width of the core index; must equal ceil(log2(NUM_CORES)).
- SHARED_BASE, 32'd128, first byte address of the shared window.
- SHARED_WORDS, 32, number of 32-bit words in the shared window.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_CORES  per-core access request; held until the matching ack.
- we  in  NUM_CORES  per-core write enable (1 = sw, 0 = lw); valid with req.
- addr_bus  in  32*NUM_CORES  byte address; core i occupies bits [32i+31:32i].
- wdata_bus  in  32*NUM_CORES  write data, same packing as addr_bus.
- ack  out  NUM_CORES  one-cycle completion pulse to the winning core.
- rdata  out  32  read data, valid in the ack cycle.
- err  out  1  one-cycle pulse with ack when the address was unaligned or outside the window.
- mem_en  out  1  shared RAM access strobe.
- mem_we  out  1  shared RAM write enable.
- mem_addr  out  5  shared RAM word index.
- mem_wdata  out  32  shared RAM write data.
- mem_rdata  in  32  shared RAM read data; combinational from mem_addr.
- grant_idx  out  IDX_W  index of the current or last owner (debug).

Behaviour:
- Reset (asynchronous) forces state=IDLE, ack=0, err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, grant_idx=0, rr_ptr=NUM_CORES-1. The pointer value makes core 0 win first. Reset mid-access abandons the access; no ack is issued.
- States: IDLE, ACCESS, ACK (plus LOCKED when the optional feature is compiled in).
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CORES.
  - Register the winner's index, we, address and wdata, then go to ACCESS.
  - If req is zero, stay in IDLE.
- ACCESS (exactly one cycle):
  - If the address is aligned (addr[1:0]==0) and satisfies SHARED_BASE <= addr < SHARED_BASE+4*SHARED_WORDS: drive mem_en=1, mem_we=registered we, mem_addr=(addr-SHARED_BASE)>>2, mem_wdata. Capture mem_rdata into rdata when we=0.
  - Otherwise: mem_en=0, rdata=0, set the error flag.
  - Go to ACK.
- ACK (exactly one cycle):
  - ack[winner]=1; err=flag.
  - rr_ptr<=winner; go to IDLE.
- Latency: req seen in cycle t gives mem_en in t+1 and ack in t+2. A lone requester therefore completes every 3 cycles.
- Requester rule: a core drops req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Fairness: with all cores requesting continuously, grant order is 0,1,2,3,0,... Worst-case wait is 3*NUM_CORES cycles.
- A write returns ack with rdata=0. A read's rdata holds its value until the next read completes.
- Changes to req, we, addr or wdata by non-winning cores during ACCESS/ACK have no effect. Those cores are arbitrated on return to IDLE.

Optional Feature:
- Macro: SHARED_ARB_LOCK_EN.
- With it defined:
  - Adds input lock[NUM_CORES] and state LOCKED.
  - If lock[winner]=1 in ACK, go to LOCKED instead of IDLE and keep rr_ptr unchanged.
  - In LOCKED, only the owner's req is honoured and goes directly to ACCESS; other requests wait.
  - When lock[owner] falls, set rr_ptr<=owner and go to IDLE.
  - Reset clears ownership. This supports atomic read-modify-write on shared counters.
- Without it: there is no lock port, the LOCKED state is absent, and every access is arbitrated.

Decomposition:
- Shared package (mips_mc_pkg): state encoding constants (IDLE, ACCESS, ACK, LOCKED), SHARED_BASE, SHARED_WORDS, and shared word-index width 5.
- One natural sub-module: rr_pick. Combinational round-robin selector with inputs req and rr_ptr, outputs winner index and a valid bit; shared with any future I/O arbiter.

Test Plan:
- Reset, then core 1 lw addr 128 with RAM[0]=50 -> mem_en at t+1 with mem_addr=0, ack[1] at t+2 with rdata=50, err=0.
- Cores 0-3 hold req on sw to 144 with wdata=i -> ack order 0,1,2,3 at 3-cycle spacing; RAM[4] ends at 3.
- Core 2 lw addr 132 (RAM[1]=25) concurrent with core 0 sw 0 -> core 0 acks first, core 2 gets rdata=25 three cycles later.
- Core 3 lw addr 4, then lw addr 130 -> each gives ack[3] with err=1, mem_en stays 0, rdata=0.
- Reset asserted in the ACCESS cycle -> no ack, mem_en=0 immediately; after release, core 0 wins the first arbitration.
- SHARED_ARB_LOCK_EN: core 1 locks, lw 128 then sw 128=51 while core 0 requests -> core 0 is served only after lock[1] falls; its read returns 51.
